// File: rtl/hash_byte_feeder.sv
// hash_byte_feeder: buffers producer bytes (with an end-of-message flag) in a
// small circular FIFO and replays them to a full_hash core through its
// start / F_rtr / F_dr / End_Of_File / H_ready handshake, one message at a time.
module hash_byte_feeder #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_byte,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   start,
  output logic [7:0]             Byte,
  output logic                   F_dr,
  output logic                   End_Of_File,
  input  logic                   F_rtr,
  input  logic                   H_ready,
  output logic                   busy,
  output logic [15:0]            msg_bytes,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C    = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1'b1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_RTR = 3'd2,
    SEND     = 3'd3,
    GAP      = 3'd4,
    EOF_WAIT = 3'd5
  } state_t;

  // FIFO storage: each entry is {last, byte}
  logic [8:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_s;
  logic [8:0]    head_s;

  state_t state_r;
  state_t state_s;
  logic   push_s;
  logic   pop_s;
  logic   clr_msg_s;

  // Registered outputs and popped-entry bookkeeping
  logic        in_ready_r;
  logic        start_r;
  logic        f_dr_r;
  logic        eof_r;
  logic        busy_r;
  logic [7:0]  byte_r;
  logic        last_r;
  logic [15:0] msg_r;

  assign head_s = mem_r[rd_ptr_r];
  // in_ready_r is already low when full, so a same-cycle pop never admits a push
  assign push_s = in_valid && in_ready_r;

  // Next-state logic: decides the pop and the message-counter clear
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    clr_msg_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != ZERO_C) begin
          state_s   = START;
          clr_msg_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        state_s = WAIT_RTR;
      end
      WAIT_RTR: begin
        if (F_rtr && (count_r != ZERO_C)) begin
          state_s = SEND;
          pop_s   = 1'b1;
        end else begin
          state_s = WAIT_RTR;
        end
      end
      SEND: begin
        state_s = GAP;
      end
      GAP: begin
        if (last_r) begin
          state_s = EOF_WAIT;
        end else begin
          state_s = WAIT_RTR;
        end
      end
      EOF_WAIT: begin
        if (H_ready) begin
          state_s = IDLE;
        end else begin
          state_s = EOF_WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Next FIFO occupancy from this cycle's push/pop pair
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + ONE_C;
      2'b01:   count_s = count_r - ONE_C;
      default: count_s = count_r;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FIFO payload write; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_last, in_byte};
    end
  end

  // FIFO pointers, occupancy and registered in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= ZERO_C;
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r    <= count_s;
      in_ready_r <= (count_s != FULL_C);
    end
  end

  // Popped byte/flag capture and saturating per-message byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_r <= 8'h00;
      last_r <= 1'b0;
      msg_r  <= 16'h0000;
    end else begin
      if (pop_s) begin
        byte_r <= head_s[7:0];
        last_r <= head_s[8];
      end
      if (clr_msg_s) begin
        msg_r <= 16'h0000;
      end else if (pop_s && (msg_r != 16'hFFFF)) begin
        msg_r <= msg_r + 16'h0001;
      end
    end
  end

  // Handshake outputs registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r <= 1'b0;
      f_dr_r  <= 1'b0;
      eof_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      start_r <= (state_s == START);
      f_dr_r  <= (state_s == SEND);
      eof_r   <= (state_s == EOF_WAIT);
      busy_r  <= (state_s != IDLE);
    end
  end

  assign in_ready    = in_ready_r;
  assign start       = start_r;
  assign Byte        = byte_r;
  assign F_dr        = f_dr_r;
  assign End_Of_File = eof_r;
  assign busy        = busy_r;
  assign msg_bytes   = msg_r;
  assign fifo_count  = count_r;

endmodule

// File: doc/hash_byte_feeder.md
HASH_BYTE_FEEDER -- requirements
Module: hash_byte_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  producer offers in_byte/in_last this cycle.
REQ-005 SHALL have port in_byte  input  8  message byte from producer.
REQ-006 SHALL have port in_last  input  1  marks in_byte as final byte of a message.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept; push occurs when in_valid&&in_ready.
REQ-008 SHALL have port start  output  1  one-cycle pulse opening a message to full_hash.
REQ-009 SHALL have port Byte  output  8  byte presented to full_hash.
REQ-010 SHALL have port F_dr  output  1  one-cycle data-ready strobe qualifying Byte.
REQ-011 SHALL have port End_Of_File  output  1  level: message complete, held until H_ready.
REQ-012 SHALL have port F_rtr  input  1  full_hash ready to receive a byte.
REQ-013 SHALL have port H_ready  input  1  full_hash hash result valid.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port msg_bytes  output  16  bytes sent in current/last message, saturating.
REQ-016 SHALL have port fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL store 9-bit entries {in_last,in_byte} in a DEPTH-entry circular FIFO; pointers wrap modulo DEPTH.
REQ-018 SHALL drive in_ready = (fifo_count < DEPTH); no push when full, even if a pop occurs that cycle.
REQ-019 SHALL support push and pop in the same cycle (count unchanged) when not full.
REQ-020 SHALL implement FSM states IDLE, START, WAIT_RTR, SEND, GAP, EOF_WAIT; all outputs registered.
REQ-021 IDLE: when fifo_count!=0, go to START; clear msg_bytes on this transition.
REQ-022 START: start=1 for exactly one cycle, then WAIT_RTR.
REQ-023 WAIT_RTR: when F_rtr==1 and fifo_count!=0, pop head, load Byte, go to SEND; otherwise hold.
REQ-024 SEND: F_dr=1 for exactly one cycle; msg_bytes += 1 (saturating at 65535); go to GAP.
REQ-025 GAP: F_dr=0 for one cycle; to EOF_WAIT if popped entry had last=1, else WAIT_RTR.
REQ-026 Byte SHALL stay stable from SEND until the next pop; F_dr never high two consecutive cycles.
REQ-027 EOF_WAIT: End_Of_File=1; when H_ready==1 sampled, go to IDLE with End_Of_File=0 next cycle.
REQ-028 H_ready SHALL be ignored outside EOF_WAIT; F_rtr ignored outside WAIT_RTR.
REQ-029 Pushes of the next message SHALL be accepted in any state; they are not popped until after IDLE->START.
REQ-030 Latency: first F_dr no earlier than 3 cycles after first push into an empty FIFO in IDLE (IDLE, START, WAIT_RTR).
REQ-031 Per-byte throughput with F_rtr held 1: one F_dr every 3 cycles.

Reset
REQ-032 On rst_n=0, immediately (asynchronously): state=IDLE, FIFO emptied, start=F_dr=End_Of_File=busy=0, Byte=0, msg_bytes=0, fifo_count=0, in_ready=1.
REQ-033 Reset mid-message SHALL discard all buffered bytes; no start/F_dr pulse emitted until new data pushed after release.

Verification
REQ-034 Reset release, no input -> all outputs 0, in_ready=1 for 20 cycles.
REQ-035 Push "CiaoMondo" (0x43 69 61 6F 4D 6F 6E 64 6F, last on final 0x6F), F_rtr=1 -> one start pulse, 9 F_dr pulses 3 cycles apart in that order, End_Of_File=1 after final GAP; H_ready pulse -> End_Of_File=0, busy=0, msg_bytes=9.
REQ-036 F_rtr=0, push 17 bytes -> fifo_count=16, in_ready=0, 17th not accepted, no F_dr, Byte unchanged; F_rtr=1 -> 16 bytes delivered in order.
REQ-037 Full FIFO, in_valid=1 while pop occurs -> push rejected that cycle, fifo_count=15, accepted next cycle.
REQ-038 rst_n pulsed low after 4th F_dr of a 9-byte message -> outputs reset instantly, fifo_count=0, no further F_dr after release.
REQ-039 Two back-to-back 3-byte messages, H_ready held 0 for 10 cycles -> second start only after H_ready, two start pulses total, msg_bytes=3 after each.
